mem_io_resp: RTL and testbench



---
 rtl/mem_io_resp.sv | 136 +++++++++++++
 tb/tb_mem_io_resp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_resp.sv
// CPU memory/IO responder: byte RAM, RX input port, TX FIFO toward a UART,
// free-running cycle counter with snapshot latch, and a sticky halt flag.
module mem_io_resp #(
    parameter int unsigned RAM_AW   = 17,
    parameter int unsigned TX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt,
    output logic        tx_overflow
);
    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);
    localparam logic [CW-1:0] NEAR_C  = CW'(TX_DEPTH - 2);

    logic [7:0]    ram_mem  [0:(2**RAM_AW)-1];
    logic [7:0]    fifo_mem [0:TX_DEPTH-1];

    logic [7:0]    rdata_q, rdata_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   latch_q, latch_d;
    logic          halt_q, halt_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          is_io, is_ram, wr_ok, enq, deq, accept;
    logic [15:0]   io_off;
    logic [7:0]    enq_byte;
    logic          unused_a;

    assign unused_a = ^mem_a[31:18];
    assign is_io    = (mem_a[17:16] == 2'b11);
    assign is_ram   = ~mem_a[17];
    assign io_off   = mem_a[15:0];
    assign wr_ok    = mem_wr & ~halt_q;

    assign tx_valid       = (count_q != '0);
    assign tx_data        = fifo_mem[rptr_q];
    assign io_buffer_full = (count_q >= NEAR_C);
    assign deq            = tx_valid & tx_ready;
    assign halt           = halt_q;
    assign tx_overflow    = ovf_q;
    assign mem_rdata      = rdata_q;
    // Gated by reset so no byte is consumed while the block is held in reset.
    assign rx_pop = rst_in & ~mem_wr & is_io & (io_off == 16'h0000) & rx_valid;

    always_comb begin
        rdata_d  = '0;
        latch_d  = latch_q;
        halt_d   = halt_q;
        enq      = 1'b0;
        enq_byte = mem_wdata;
        cnt_d    = cnt_q + 32'd1;
        if (!mem_wr) begin
            if (is_ram) begin
                rdata_d = ram_mem[mem_a[RAM_AW-1:0]];
            end else if (is_io) begin
                case (io_off)
                    16'h0000: if (rx_valid) rdata_d = rx_data;
                    16'h0004: begin
                        latch_d = cnt_q;
                        rdata_d = cnt_q[7:0];
                    end
                    16'h0005: rdata_d = latch_q[15:8];
                    16'h0006: rdata_d = latch_q[23:16];
                    16'h0007: rdata_d = latch_q[31:24];
                    default:  rdata_d = '0;
                endcase
            end
        end else if (wr_ok && is_io) begin
            if (io_off == 16'h0000 && mem_wdata != 8'h00) begin
                enq = 1'b1;
            end else if (io_off == 16'h0004) begin
                halt_d   = 1'b1;
                enq      = 1'b1;
                enq_byte = '0;
            end
        end
    end

    // A full FIFO still accepts when the head leaves in the same cycle.
    always_comb begin
        accept  = enq & ((count_q < DEPTH_C) | deq);
        ovf_d   = ovf_q | (enq & ~accept);
        wptr_d  = accept ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = deq ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        case ({accept, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rdata_q <= '0;
            cnt_q   <= '0;
            latch_q <= '0;
            halt_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            halt_q  <= halt_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage arrays are not reset; RAM contents survive a reset.
    always_ff @(posedge clk_in) begin
        if (wr_ok && is_ram) ram_mem[mem_a[RAM_AW-1:0]] <= mem_wdata;
        if (accept) fifo_mem[wptr_q] <= enq_byte;
    end
endmodule

// File: tb/tb_mem_io_resp.sv
// Randomized and directed checks of mem_io_resp against a queue/array model.
module tb_mem_io_resp;
    localparam int DEPTH = 8;
    localparam logic [31:0] IDLE = 32'h0002_0000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_a = IDLE;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_wdata = 8'h00;
    logic [7:0]  mem_rdata;
    logic        io_buffer_full;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_pop;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        halt;
    logic        tx_overflow;

    mem_io_resp #(.RAM_AW(17), .TX_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .io_buffer_full(io_buffer_full), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_pop(rx_pop), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .halt(halt), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  ram_m [int];
    logic [7:0]  q [$];
    logic        halt_m = 1'b0;
    logic        ovf_m = 1'b0;
    logic [31:0] cnt_m = 32'd0;
    logic [31:0] latch_m = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: check combinational outputs, update the model, clock, check registered outputs.
    task automatic step(input logic [31:0] a, input logic w, input logic [7:0] d);
        logic       io, ram, known, enq, acc, dq;
        logic [7:0] nrd, eb;
        int         off, idx;
        mem_a = a; mem_wr = w; mem_wdata = d;
        #1;
        io  = (a[17:16] == 2'b11);
        ram = (a[17] == 1'b0);
        off = int'(a[15:0]);
        idx = int'(a[16:0]);
        chk("rx_pop", rx_pop, (!w && io && off == 0 && rx_valid));
        chk("tx_valid", tx_valid, (q.size() != 0));
        if (q.size() != 0) chk("tx_data", tx_data, q[0]);
        chk("io_buffer_full", io_buffer_full, (q.size() >= DEPTH - 2));
        known = 1'b1; nrd = 8'h00; enq = 1'b0; eb = d;
        if (!w) begin
            if (ram) begin
                if (ram_m.exists(idx)) nrd = ram_m[idx];
                else known = 1'b0;
            end else if (io) begin
                if (off == 0) nrd = rx_valid ? rx_data : 8'h00;
                else if (off == 4) begin latch_m = cnt_m; nrd = cnt_m[7:0]; end
                else if (off == 5) nrd = latch_m[15:8];
                else if (off == 6) nrd = latch_m[23:16];
                else if (off == 7) nrd = latch_m[31:24];
            end
        end else begin
            known = 1'b0;
            if (!halt_m) begin
                if (ram) ram_m[idx] = d;
                else if (io && off == 0 && d != 8'h00) enq = 1'b1;
                else if (io && off == 4) begin halt_m = 1'b1; enq = 1'b1; eb = 8'h00; end
            end
        end
        dq  = tx_ready && (q.size() != 0);
        acc = enq && (q.size() < DEPTH || dq);
        if (enq && !acc) ovf_m = 1'b1;
        if (dq) void'(q.pop_front());
        if (acc) q.push_back(eb);
        @(posedge clk_in);
        #1;
        cnt_m++;
        if (known) chk("mem_rdata", mem_rdata, nrd);
        chk("halt", halt, halt_m);
        chk("tx_overflow", tx_overflow, ovf_m);
    endtask

    task automatic rst(input int n);
        mem_a = 32'h0003_0000; mem_wr = 1'b0; rx_valid = 1'b1; rx_data = 8'h77;
        rst_in = 1'b0;
        #1;
        chk("rst_mem_rdata", mem_rdata, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_pop", rx_pop, 1'b0);
        chk("rst_halt", halt, 1'b0);
        chk("rst_tx_overflow", tx_overflow, 1'b0);
        chk("rst_io_buffer_full", io_buffer_full, 1'b0);
        q.delete(); halt_m = 1'b0; ovf_m = 1'b0; cnt_m = 0; latch_m = 0;
        repeat (n) @(posedge clk_in);
        #1;
        rst_in = 1'b1; rx_valid = 1'b0; mem_a = IDLE;
    endtask

    initial begin
        logic [31:0] a, snap, got;
        logic        w;
        logic [7:0]  d;
        #2;
        rst(3);

        step(32'h10, 1'b1, 8'hA5);
        step(32'h10, 1'b0, 8'h00);
        chk("ram_readback", mem_rdata, 8'hA5);

        rx_valid = 1'b1; rx_data = 8'h41;
        step(32'h0003_0000, 1'b0, 8'h00);
        chk("rx_read", mem_rdata, 8'h41);
        rx_valid = 1'b0;
        step(32'h0003_0000, 1'b0, 8'h00);
        chk("rx_read_empty", mem_rdata, 8'h00);

        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(32'h0003_0000, 1'b1, 8'(8'h31 + i));
        chk("fifo_full_near", io_buffer_full, 1'b1);
        step(32'h0003_0000, 1'b1, 8'h39);
        chk("overflow_set", tx_overflow, 1'b1);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_order", tx_data, 8'(8'h31 + i));
            step(IDLE, 1'b0, 8'h00);
        end
        step(IDLE, 1'b0, 8'h00);

        for (int i = 0; i < 300; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            case ($urandom_range(0, 4))
                0, 1:    a = 32'($urandom_range(0, 15));
                2:       a = 32'h0002_0000 + 32'($urandom_range(0, 255));
                3:       a = 32'h0003_0000 + 32'($urandom_range(0, 8));
                default: a = 32'hFFFC_0000 | 32'($urandom_range(0, 15));
            endcase
            w = 1'($urandom_range(0, 1));
            if (w && a[17:0] == 18'h30004) w = 1'b0;
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            step(a, w, d);
        end

        rx_valid = 1'b0; tx_ready = 1'b1;
        repeat (DEPTH + 2) step(IDLE, 1'b0, 8'h00);
        tx_ready = 1'b0;
        step(32'h0003_0000, 1'b1, 8'h00);
        chk("zero_filtered", tx_valid, 1'b0);
        step(32'h0003_0004, 1'b1, 8'hEE);
        chk("halt_set", halt, 1'b1);
        chk("halt_byte", tx_data, 8'h00);
        step(32'h10, 1'b1, 8'h5A);
        step(32'h10, 1'b0, 8'h00);
        chk("halt_write_ignored", mem_rdata, 8'hA5);
        tx_ready = 1'b1;
        step(IDLE, 1'b0, 8'h00);
        chk("halt_byte_drained", tx_valid, 1'b0);

        rst(100);
        repeat (3) step(IDLE, 1'b0, 8'h00);
        snap = cnt_m;
        step(32'h0003_0004, 1'b0, 8'h00); got[7:0]   = mem_rdata;
        step(32'h0003_0005, 1'b0, 8'h00); got[15:8]  = mem_rdata;
        step(32'h0003_0006, 1'b0, 8'h00); got[23:16] = mem_rdata;
        step(32'h0003_0007, 1'b0, 8'h00); got[31:24] = mem_rdata;
        chk("counter_snapshot", got, snap);
        chk("counter_after_reset", got, 32'd3);

        tx_ready = 1'b0;
        step(32'h20, 1'b1, 8'h3C);
        for (int i = 0; i < 3; i++) step(32'h0003_0000, 1'b1, 8'(8'h61 + i));
        step(32'h10, 1'b0, 8'h00);
        rst(2);
        step(32'h20, 1'b0, 8'h00);
        chk("ram_kept_20", mem_rdata, 8'h3C);
        step(32'h10, 1'b0, 8'h00);
        chk("ram_kept_10", mem_rdata, 8'hA5);
        chk("fifo_cleared", tx_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
